// File: rtl/rx_pkt_pkg.sv
// rx_pkt_pkg: shared state encodings, default sync marker and width helper for the rx packet path
package rx_pkt_pkg;
   typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CSUM, HOLD} state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   localparam logic [7:0] DEFAULT_SYNC = 8'hAA;
   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/rx_packet_ctrl_serial_rx.sv
// serial_rx: 8N1 UART byte receiver
// Ports: clk, rst (active-high sync), rx (serial in, idle high),
//        data (last received byte), new_data (one-cycle byte strobe)
module serial_rx
   import rx_pkt_pkg::*;
#(
   parameter int CLK_PER_BIT = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       new_data
);
   localparam int CW = width_of(CLK_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLK_PER_BIT / 2 - 1);
   rx_state_t st_q, st_d;
   logic [CW-1:0] cnt_q, cnt_d, dly_q, dly_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] sh_q, sh_d, dat_q, dat_d;
   logic pend_q, pend_d, nd_q, nd_d;
   logic rx_meta_q, rx_s_q;
   // The strobe is delayed one bit-time past the stop-bit midpoint by a separate
   // counter, so the line FSM is already free to catch a back-to-back start bit.
   always_comb begin
      st_d = st_q;
      cnt_d = cnt_q;
      bit_d = bit_q;
      sh_d = sh_q;
      dat_d = dat_q;
      pend_d = pend_q;
      dly_d = dly_q;
      nd_d = 1'b0;
      if (pend_q) begin
         nd_d = (dly_q == LAST);
         pend_d = (dly_q != LAST);
         dly_d = dly_q + 1'b1;
      end
      case (st_q)
         RX_IDLE: begin
            st_d = rx_s_q ? RX_IDLE : RX_START;
            cnt_d = '0;
         end
         RX_START: begin
            cnt_d = (cnt_q == HALF) ? '0 : cnt_q + 1'b1;
            bit_d = '0;
            if (cnt_q == HALF) st_d = rx_s_q ? RX_IDLE : RX_DATA;
         end
         RX_DATA: begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               sh_d = {rx_s_q, sh_q[7:1]};
               bit_d = bit_q + 1'b1;
               st_d = (bit_q == 3'd7) ? RX_STOP : RX_DATA;
            end
         end
         RX_STOP: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               st_d = RX_IDLE;
               if (rx_s_q) begin
                  dat_d = sh_q;
                  pend_d = 1'b1;
                  dly_d = '0;
               end
            end
         end
         default: st_d = RX_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q <= 1'b1;
         st_q <= RX_IDLE;
         cnt_q <= '0;
         bit_q <= '0;
         sh_q <= '0;
         dat_q <= '0;
         pend_q <= 1'b0;
         dly_q <= '0;
         nd_q <= 1'b0;
      end else begin
         rx_meta_q <= rx;
         rx_s_q <= rx_meta_q;
         st_q <= st_d;
         cnt_q <= cnt_d;
         bit_q <= bit_d;
         sh_q <= sh_d;
         dat_q <= dat_d;
         pend_q <= pend_d;
         dly_q <= dly_d;
         nd_q <= nd_d;
      end
   end
   assign data = dat_q;
   assign new_data = nd_q;
endmodule

// File: rtl/rx_packet_ctrl.sv
// rx_packet_ctrl: UART packet framer (SYNC, LEN, payload, CSUM) with buffered valid/ready output
// Ports: clk, rst (active-low sync), rx (serial in),
//        pkt_valid/pkt_ready (held-packet handshake), pkt_len (held length),
//        rd_addr/rd_data (combinational payload read),
//        csum_err/len_err/timeout_err/overrun (one-cycle pulses), busy (not hunting)
module rx_packet_ctrl
   import rx_pkt_pkg::*;
#(
   parameter int CLK_PER_BIT = 50,
   parameter int MAX_LEN = 16,
   parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC,
   parameter int TIMEOUT_CLKS = 1000,
   localparam int LW = width_of(MAX_LEN + 1),
   localparam int AW = width_of(MAX_LEN)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rx,
   output logic          pkt_valid,
   input  logic          pkt_ready,
   output logic [LW-1:0] pkt_len,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data,
   output logic          csum_err,
   output logic          len_err,
   output logic          timeout_err,
   output logic          overrun,
   output logic          busy
);
   localparam int TW = width_of(TIMEOUT_CLKS);
   state_t state_q, state_d;
   logic [LW-1:0] len_q, len_d, idx_q, idx_d, pkt_len_q, pkt_len_d;
   logic [7:0] sum_q, sum_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic csum_err_q, csum_err_d, len_err_q, len_err_d;
   logic timeout_err_q, timeout_err_d, overrun_q, overrun_d;
   logic [7:0] buf_q [MAX_LEN];
   logic [7:0] buf_d [MAX_LEN];
   logic byte_vld;
   logic [7:0] byte_data;
   serial_rx #(.CLK_PER_BIT(CLK_PER_BIT)) u_rx (
      .clk(clk),
      .rst(~rst),
      .rx(rx),
      .data(byte_data),
      .new_data(byte_vld)
   );
   always_comb begin
      state_d = state_q;
      len_d = len_q;
      idx_d = idx_q;
      sum_d = sum_q;
      pkt_len_d = pkt_len_q;
      tmo_d = '0;
      csum_err_d = 1'b0;
      len_err_d = 1'b0;
      timeout_err_d = 1'b0;
      overrun_d = 1'b0;
      buf_d = buf_q;
      // A byte event in the expiry cycle wins: the timeout branch only runs without one.
      if (state_q inside {LEN, PAYLOAD, CSUM} && !byte_vld) begin
         timeout_err_d = (tmo_q == TW'(TIMEOUT_CLKS - 1));
         tmo_d = timeout_err_d ? '0 : tmo_q + 1'b1;
         if (timeout_err_d) state_d = HUNT;
      end
      case (state_q)
         HUNT: if (byte_vld && byte_data == SYNC_BYTE) state_d = LEN;
         LEN: if (byte_vld) begin
            len_d = LW'(byte_data);
            sum_d = byte_data;
            idx_d = '0;
            len_err_d = int'(byte_data) > MAX_LEN;
            state_d = len_err_d ? HUNT : (byte_data == 8'd0) ? CSUM : PAYLOAD;
         end
         PAYLOAD: if (byte_vld) begin
            buf_d[idx_q[AW-1:0]] = byte_data;
            sum_d = sum_q + byte_data;
            idx_d = idx_q + 1'b1;
            if (idx_q == len_q - 1'b1) state_d = CSUM;
         end
         CSUM: if (byte_vld) begin
            csum_err_d = (byte_data != sum_q);
            pkt_len_d = csum_err_d ? pkt_len_q : len_q;
            state_d = csum_err_d ? HUNT : HOLD;
         end
         // Bytes arriving while a packet is held are dropped, even a SYNC.
         HOLD: begin
            overrun_d = byte_vld;
            if (pkt_ready) state_d = HUNT;
         end
         default: state_d = HUNT;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= HUNT;
         len_q <= '0;
         idx_q <= '0;
         sum_q <= '0;
         pkt_len_q <= '0;
         tmo_q <= '0;
         csum_err_q <= 1'b0;
         len_err_q <= 1'b0;
         timeout_err_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q <= len_d;
         idx_q <= idx_d;
         sum_q <= sum_d;
         pkt_len_q <= pkt_len_d;
         tmo_q <= tmo_d;
         csum_err_q <= csum_err_d;
         len_err_q <= len_err_d;
         timeout_err_q <= timeout_err_d;
         overrun_q <= overrun_d;
      end
   end
   always_ff @(posedge clk) buf_q <= buf_d;
   assign pkt_valid = (state_q == HOLD);
   assign busy = (state_q != HUNT);
   assign pkt_len = pkt_len_q;
   assign rd_data = (pkt_valid && LW'(rd_addr) < pkt_len_q) ? buf_q[rd_addr] : 8'h00;
   assign csum_err = csum_err_q;
   assign len_err = len_err_q;
   assign timeout_err = timeout_err_q;
   assign overrun = overrun_q;
endmodule

// File: tb/tb_rx_packet_ctrl.sv
// tb_rx_packet_ctrl: randomized scoreboard bench for rx_packet_ctrl with a frame-level reference model
module tb_rx_packet_ctrl;
   localparam int CPB = 16;
   localparam int MAXL = 16;
   localparam int TMO = 1000;
   localparam int EV_PKT = 0;
   localparam int EV_CSUM = 1;
   localparam int EV_LEN = 2;
   localparam int EV_TMO = 3;
   localparam int EV_OVR = 4;
   typedef struct packed {
      int kind;
      int len;
      logic [MAXL-1:0][7:0] pl;
   } ev_t;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic rx = 1'b1;
   logic pkt_ready = 1'b0;
   logic [3:0] rd_addr = 4'd0;
   logic pkt_valid, csum_err, len_err, timeout_err, overrun, busy;
   logic [4:0] pkt_len;
   logic [7:0] rd_data;
   int n_chk = 0;
   int n_fail = 0;
   ev_t exp_q[$];
   logic [7:0] fq[$];
   bit model_hold = 1'b0;
   bit release_pkt = 1'b1;
   int hold_min = 20;
   bit holding = 1'b0;
   ev_t cur;
   int rdp, hc;

   rx_packet_ctrl #(.CLK_PER_BIT(CPB), .MAX_LEN(MAXL), .SYNC_BYTE(8'hAA), .TIMEOUT_CLKS(TMO)) dut (
      .clk(clk),
      .rst(rst),
      .rx(rx),
      .pkt_valid(pkt_valid),
      .pkt_ready(pkt_ready),
      .pkt_len(pkt_len),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .csum_err(csum_err),
      .len_err(len_err),
      .timeout_err(timeout_err),
      .overrun(overrun),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push_kind(input int kind);
      ev_t e;
      e = '0;
      e.kind = kind;
      exp_q.push_back(e);
   endtask

   // Frame-level model: collect a whole frame into a queue, judge it once complete.
   task automatic model_byte(input logic [7:0] b);
      ev_t e;
      logic [7:0] s;
      if (model_hold) push_kind(EV_OVR);
      else if (fq.size() == 0) begin
         if (b == 8'hAA) fq.push_back(b);
      end else begin
         fq.push_back(b);
         if (fq.size() == 2 && int'(fq[1]) > MAXL) begin
            push_kind(EV_LEN);
            fq.delete();
         end else if (fq.size() == int'(fq[1]) + 3) begin
            s = 8'd0;
            for (int i = 1; i < fq.size() - 1; i++) s += fq[i];
            if (s == b) begin
               e = '0;
               e.kind = EV_PKT;
               e.len = int'(fq[1]);
               for (int i = 0; i < e.len; i++) e.pl[i] = fq[i+2];
               exp_q.push_back(e);
               model_hold = !release_pkt;
            end else push_kind(EV_CSUM);
            fq.delete();
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      model_byte(b);
      @(negedge clk);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = 1'b1;
      repeat (CPB + int'($urandom_range(0, 20))) @(negedge clk);
   endtask

   task automatic send_list(input logic [7:0] q[$]);
      foreach (q[i]) send_byte(q[i]);
   endtask

   task automatic idle(input int n);
      if (n > TMO && fq.size() != 0) begin
         push_kind(EV_TMO);
         fq.delete();
      end
      repeat (n) @(negedge clk);
   endtask

   task automatic drain();
      int t = 0;
      idle(3 * CPB);
      while ((exp_q.size() != 0 || (holding && release_pkt)) && t < 5000) begin
         @(negedge clk);
         t++;
      end
      chk("pending events", exp_q.size(), 0);
   endtask

   task automatic chk_reset();
      chk("reset pkt_valid", pkt_valid, 0);
      chk("reset pkt_len", pkt_len, 0);
      chk("reset csum_err", csum_err, 0);
      chk("reset len_err", len_err, 0);
      chk("reset timeout_err", timeout_err, 0);
      chk("reset overrun", overrun, 0);
      chk("reset busy", busy, 0);
   endtask

   task automatic rand_frame();
      logic [7:0] q[$];
      logic [7:0] s, b;
      int len;
      if ($urandom_range(0, 2) == 0) begin
         b = 8'($urandom);
         q.push_back(b == 8'hAA ? 8'h55 : b);
      end
      q.push_back(8'hAA);
      len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(MAXL + 1, 255)) : int'($urandom_range(0, MAXL));
      q.push_back(len[7:0]);
      if (len <= MAXL) begin
         s = len[7:0];
         for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            s += b;
         end
         if ($urandom_range(0, 3) == 0) s ^= 8'(1 << $urandom_range(0, 7));
         q.push_back(s);
      end
      send_list(q);
   endtask

   task automatic pop_ev(input int kind, output ev_t e);
      if (exp_q.size() == 0) begin
         e = '0;
         chk("unexpected event kind", kind, -1);
      end else begin
         e = exp_q.pop_front();
         chk("event kind", kind, e.kind);
      end
   endtask

   // Monitor and consumer: pops the scoreboard on every DUT output event.
   initial begin
      ev_t d;
      forever begin
         @(negedge clk);
         #1;
         if (!rst) begin
            holding = 1'b0;
            pkt_ready = 1'b0;
         end else begin
            if (csum_err) begin
               pop_ev(EV_CSUM, d);
               chk("busy after csum_err", busy, 0);
            end
            if (len_err) begin
               pop_ev(EV_LEN, d);
               chk("busy after len_err", busy, 0);
            end
            if (timeout_err) begin
               pop_ev(EV_TMO, d);
               chk("busy after timeout_err", busy, 0);
            end
            if (overrun) pop_ev(EV_OVR, d);
            if (pkt_ready) begin
               pkt_ready = 1'b0;
               chk("pkt_valid after accept", pkt_valid, 0);
               holding = 1'b0;
            end else if (holding) begin
               chk("pkt_valid held", pkt_valid, 1);
               chk("pkt_len stable", pkt_len, cur.len);
               chk("busy in hold", busy, 1);
               rd_addr = 4'(rdp);
               #1;
               chk("rd_data", rd_data, (rdp < cur.len) ? int'(cur.pl[rdp]) : 0);
               rdp = (rdp + 1) % MAXL;
               hc++;
               if (!pkt_valid) holding = 1'b0;
               else if (hc >= hold_min && hc >= MAXL && release_pkt) pkt_ready = 1'b1;
            end else if (pkt_valid) begin
               pop_ev(EV_PKT, cur);
               chk("pkt_len", pkt_len, cur.len);
               holding = 1'b1;
               rdp = 0;
               hc = 0;
            end else if ($urandom_range(0, 15) == 0) begin
               rd_addr = 4'($urandom);
               #1;
               chk("rd_data idle", rd_data, 0);
            end
         end
      end
   end

   initial begin
      #(95000 * 10);
      $display("FAIL watchdog: got no finish, expected finish within budget");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] q[$];
      repeat (3) @(negedge clk);
      #1;
      chk_reset();
      @(negedge clk);
      rst = 1'b1;
      hold_min = 100;
      q = '{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
      send_list(q);
      drain();
      hold_min = 20;
      q = '{8'hAA, 8'h00, 8'h00, 8'hAA, 8'h02, 8'h01, 8'h02, 8'h00, 8'hAA, 8'h11, 8'hAA, 8'h01, 8'h5A, 8'h5B};
      send_list(q);
      drain();
      q = '{8'h00, 8'hFF, 8'hAA, 8'h02, 8'h01};
      send_list(q);
      idle(TMO + 300);
      drain();
      release_pkt = 1'b0;
      q = '{8'hAA, 8'h02, 8'h42, 8'h07, 8'h4B};
      send_list(q);
      idle(3 * CPB);
      q = '{8'hAA, 8'h01, 8'h10, 8'h11};
      send_list(q);
      drain();
      release_pkt = 1'b1;
      model_hold = 1'b0;
      drain();
      q = '{8'hAA, 8'h02, 8'hAA, 8'h55, 8'h01};
      send_list(q);
      drain();
      q = '{8'hAA, 8'h04, 8'h01};
      send_list(q);
      idle(3 * CPB);
      chk("busy mid-frame", busy, 1);
      @(negedge clk);
      rst = 1'b0;
      fq.delete();
      @(negedge clk);
      #1;
      chk_reset();
      rst = 1'b1;
      q = '{8'hAA, 8'h01, 8'h5A, 8'h5B};
      send_list(q);
      drain();
      repeat (14) rand_frame();
      drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
